// File: rtl/m_store_buffer.sv
// rtl/m_store_buffer.sv - posted-store buffer with write combining and load forwarding
//
// Purpose:
//   Sits directly upstream of the M-stage data memory write port. Stores from
//   the M stage are queued in a small circular FIFO and drained one word-write
//   per cycle into DM. A store to the same word as the youngest entry is merged
//   into that entry. M-stage loads see buffered bytes through a combinational
//   forwarding path so they never observe stale DM contents.
//
// Optional build macro:
//   SB_DISPLAY_EN - when defined, every pop prints the architectural write
//                   trace line "<time>@<pc>: *<addr> <= <merged word>".
//
// Ports:
//   clk          in   1        clock, rising-edge
//   reset        in   1        asynchronous active-low reset
//   st_valid     in   1        M stage presents a store
//   st_ready     out  1        store accepted this cycle (room or merge)
//   st_addr      in   32       store byte address, word granular
//   st_wdata     in   32       lane-aligned store data
//   st_be        in   4        store byte enables
//   st_pc        in   32       PC of the store, carried for trace
//   ld_addr      in   32       M-stage load address, word granular
//   ld_fwd_data  out  32       forwarded bytes, uncovered lanes read 0
//   ld_fwd_mask  out  4        lanes supplied by the buffer
//   dm_we        out  1        head entry presented to DM
//   dm_ready     in   1        DM accepts the presented write
//   dm_addr      out  32       head entry word address
//   dm_wdata     out  32       head entry data
//   dm_be        out  4        head entry byte enables
//   dm_pc        out  32       PC of the last store merged into the head entry
//   empty        out  1        no entries occupied
//   count        out  PTR_W+1  number of occupied entries

module m_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_wdata,
  input  logic [3:0]       st_be,
  input  logic [31:0]      st_pc,
  input  logic [31:0]      ld_addr,
  output logic [31:0]      ld_fwd_data,
  output logic [3:0]       ld_fwd_mask,
  output logic             dm_we,
  input  logic             dm_ready,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  output logic [3:0]       dm_be,
  output logic [31:0]      dm_pc,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [29:0]      ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [3:0]       ent_be   [DEPTH];
  logic [31:0]      ent_pc   [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   cnt_q;

  logic [PTR_W-1:0] young_idx;
  logic             not_full;
  logic             pop;
  logic             merge_hit;
  logic             do_merge;
  logic             do_alloc;

  // Word-offset bits of the addresses carry no information here.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

  assign young_idx = tail - PTR_W'(1);
  assign not_full  = (cnt_q < DEPTH_C);

  assign dm_we = (cnt_q != '0);
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign pop   = dm_we & dm_ready;

  // Merge into the youngest entry unless that entry is also the head leaving
  // this cycle; in that case the store allocates a fresh entry instead.
  assign merge_hit = (cnt_q != '0) &&
                     (st_addr[31:2] == ent_addr[young_idx]) &&
                     !((cnt_q == (PTR_W + 1)'(1)) && pop);

  // A merge needs no free slot, so it is accepted even when full. A drain in
  // the same cycle does not free a slot for a new allocation.
  assign st_ready = not_full | merge_hit;
  assign do_merge = st_valid & merge_hit;
  assign do_alloc = st_valid & not_full & ~merge_hit;

  assign dm_addr  = {ent_addr[head], 2'b00};
  assign dm_wdata = ent_data[head];
  assign dm_be    = ent_be[head];
  assign dm_pc    = ent_pc[head];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        ent_be[i]   <= '0;
        ent_pc[i]   <= '0;
      end
    end else begin
      if (do_merge) begin
        for (int k = 0; k < 4; k++) begin
          if (st_be[k]) begin
            ent_data[young_idx][8*k +: 8] <= st_wdata[8*k +: 8];
          end
        end
        ent_be[young_idx] <= ent_be[young_idx] | st_be;
        ent_pc[young_idx] <= st_pc;
      end

      if (do_alloc) begin
        ent_addr[tail] <= st_addr[31:2];
        ent_data[tail] <= st_wdata;
        ent_be[tail]   <= st_be;
        ent_pc[tail]   <= st_pc;
        tail           <= tail + PTR_W'(1);
      end

      if (pop) begin
        head <= head + PTR_W'(1);
      end

      case ({do_alloc, pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Walk occupied entries oldest to youngest so a younger matching lane
  // overrides an older one. Only registered entries are visible; a store
  // pushed this cycle shows up on the next.
  logic [PTR_W-1:0] fwd_idx;

  always_comb begin
    ld_fwd_data = '0;
    ld_fwd_mask = '0;
    fwd_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head + PTR_W'(i);
      if (((PTR_W + 1)'(i) < cnt_q) && (ent_addr[fwd_idx] == ld_addr[31:2])) begin
        for (int k = 0; k < 4; k++) begin
          if (ent_be[fwd_idx][k]) begin
            ld_fwd_data[8*k +: 8] = ent_data[fwd_idx][8*k +: 8];
            ld_fwd_mask[k]        = 1'b1;
          end
        end
      end
    end
  end

`ifdef SB_DISPLAY_EN
  // The buffer owns the architectural write trace; disabled lanes print as 0.
  logic [31:0] merged_word;

  always_comb begin
    merged_word = '0;
    for (int k = 0; k < 4; k++) begin
      if (dm_be[k]) begin
        merged_word[8*k +: 8] = dm_wdata[8*k +: 8];
      end
    end
  end

  always @(posedge clk) begin
    if (reset && pop) begin
      $display("%d@%h: *%h <= %h", $time, dm_pc, dm_addr, merged_word);
    end
  end
`else
`endif

endmodule
